timer_share_ctrl: RTL and testbench
===================================

// Module: timer_share_ctrl
// PURPOSE
//   Round-robin controller sharing one free-running 16-bit interval timer among N requesters.
//   Grants the timer to one requester at a time and drives the timer enable (t_en) while the grant is held.
//   Snapshots the timer count at start and stop, then reports the elapsed count, tagged with requester id.
//   Sits between the user-side measurement clients and the shared timer instance in the board top level.
// PARAMETERS
//   N        4     number of requesters, 2..16
//   W        16    timer/result width in bits
//   TIMEOUT  1000  max RUN-state cycles per grant before forced stop, >=1
// PORTS
//   clock        in   1          system clock
//   reset        in   1          asynchronous, active-high reset
//   req          in   N          per-requester measurement request, level
//   done         in   N          per-requester stop strobe; only bit [gnt_id] is honoured
//   grant        out  N          one-hot grant, registered
//   t_en         out  1          shared timer enable, high in START and RUN only
//   t_out        in   W          shared timer count value
//   res_valid    out  1          one-cycle result strobe
//   res_id       out  clog2(N)   id of the requester the result belongs to
//   res_data     out  W          elapsed count = end snapshot - start snapshot, mod 2^W
//   res_timeout  out  1          1 = measurement ended by TIMEOUT, not by done/req drop
// BEHAVIOUR
//   Reset: state=IDLE; grant=0; t_en=0; res_valid=0; res_id=0; res_data=0; res_timeout=0; rr pointer=0; snapshots=0.
//     Reset is async. Mid-operation reset drops grant and t_en at once; no result is reported.
//   FSM (all outputs decoded from registered state/regs; no comb path from req/done to outputs):
//   IDLE   : if |req, pick the first set bit searching from rr pointer upward with wrap -> gnt_id.
//            Set grant[gnt_id] -> START. req-to-grant latency is 1 cycle.
//   START  : 1 cycle; t_en=1. At the exit edge, start_snap<=t_out (pre-increment value) -> RUN; run_cnt<=1.
//   RUN    : t_en=1. Exit -> STOP when done[gnt_id] | ~req[gnt_id] | run_cnt==TIMEOUT.
//            Otherwise run_cnt++. timeout_flag<=(run_cnt==TIMEOUT) & ~done[gnt_id] & req[gnt_id].
//            done wins over timeout in the same cycle.
//   STOP   : 1 cycle; t_en=0; grant still held. At the exit edge, end_snap<=t_out -> REPORT.
//   REPORT : grant=0; res_valid=1 for exactly 1 cycle.
//            res_id=gnt_id; res_data=end_snap-start_snap (W-bit wrap subtraction); res_timeout=timeout_flag.
//            rr pointer<=(gnt_id+1) mod N -> IDLE.
//   res_id/res_data/res_timeout hold their values until the next REPORT.
//   Ideal 1-per-cycle timer: res_data = 1 + number of RUN cycles (t_en high cycles).
//   done/req changes on non-granted lines are ignored. A req still high after REPORT is re-arbitrated normally.
//   Min gap between grants: 1 IDLE cycle. Back-to-back requesters are served strictly in rr order.
//   Wrap-around of t_out between snapshots gives a correct result.
//   Intervals >= 2^W counts are aliased mod 2^W; TIMEOUT < 2^W-1 prevents this.
// TESTING (bench uses a stub counter: increments on each edge with t_en=1, presettable)
//   1) req[2] only, done[2] sampled on 3rd RUN cycle.
//      -> grant=4'b0100 one cycle after req.
//      -> res_valid with res_id=2, res_data=4, res_timeout=0.
//   2) req=4'b1011 held from IDLE, each requester drops req after 2 RUN cycles.
//      -> grants in order 0,1,3, then 0 again. Each res_data=3.
//   3) TIMEOUT=8, req[1] held high, no done.
//      -> res_id=1, res_data=9, res_timeout=1. Then req[1] is re-granted.
//   4) Stub preset 16'hFFFE, req[0], done on 3rd RUN cycle.
//      -> res_data=16'd4 across the wrap, res_timeout=0.
//   5) done[gnt_id] and timeout coincide (TIMEOUT=3, done on 3rd RUN cycle).
//      -> res_timeout=0, res_data=4.
//   6) Assert reset during RUN.
//      -> grant=0 and t_en=0 immediately, no res_valid. After release the FSM is in IDLE with rr pointer=0.

Source files
------------

// File: rtl/timer_share_ctrl_if.sv
// Client-side bundle for timer_share_ctrl: request/stop lines in, grant and tagged results out.
interface timer_share_ctrl_if #(
  parameter int N = 4,
  parameter int W = 16
) ();
  localparam int ID_W = $clog2(N);

  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [N-1:0]    grant;
  logic            res_valid;
  logic [ID_W-1:0] res_id;
  logic [W-1:0]    res_data;
  logic            res_timeout;

  modport master (
    output req, done,
    input  grant, res_valid, res_id, res_data, res_timeout
  );

  modport slave (
    input  req, done,
    output grant, res_valid, res_id, res_data, res_timeout
  );
endinterface

// File: rtl/timer_share_ctrl.sv
// Round-robin arbiter that lends one free-running interval timer to N clients and
// reports the elapsed count (end snapshot - start snapshot) tagged with the client id.
module timer_share_ctrl #(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic                clock,
  input  logic                reset,
  timer_share_ctrl_if.slave   bus,
  output logic                t_en,
  input  logic [W-1:0]        t_out
);
  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [2:0] {IDLE, START, RUN, STOP, REPORT} state_t;

  state_t          state;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] pick_id;
  logic [CNT_W-1:0] run_cnt;
  logic [W-1:0]    start_snap;
  logic            timeout_flag;
  logic [N-1:0]    grant_q;
  logic            res_valid_q;
  logic [ID_W-1:0] res_id_q;
  logic [W-1:0]    res_data_q;
  logic            res_timeout_q;
  logic            done_g;
  logic            req_g;
  logic            at_limit;
  logic [ID_W-1:0] next_ptr;

  assign bus.grant       = grant_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_id      = res_id_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_timeout = res_timeout_q;

  assign done_g   = bus.done[gnt_id];
  assign req_g    = bus.req[gnt_id];
  assign at_limit = (run_cnt == CNT_W'(TIMEOUT));
  assign next_ptr = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;

  // First requester at or above the rr pointer, wrapping modulo N.
  always_comb begin
    logic [ID_W:0] idx;
    logic          found;
    pick_id = rr_ptr;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (idx >= (ID_W + 1)'(N)) idx = idx - (ID_W + 1)'(N);
      if (!found && bus.req[idx[ID_W-1:0]]) begin
        pick_id = idx[ID_W-1:0];
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      gnt_id        <= '0;
      rr_ptr        <= '0;
      run_cnt       <= '0;
      start_snap    <= '0;
      timeout_flag  <= 1'b0;
      grant_q       <= '0;
      t_en          <= 1'b0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt_id  <= pick_id;
            grant_q <= ONE << pick_id;
            t_en    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          start_snap <= t_out;
          run_cnt    <= CNT_W'(1);
          state      <= RUN;
        end
        RUN: begin
          // done has priority over the limit, so a coinciding stop is not a timeout
          if (done_g || !req_g || at_limit) begin
            t_en         <= 1'b0;
            timeout_flag <= at_limit & ~done_g & req_g;
            state        <= STOP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        STOP: begin
          grant_q       <= '0;
          res_valid_q   <= 1'b1;
          res_id_q      <= gnt_id;
          res_data_q    <= t_out - start_snap;
          res_timeout_q <= timeout_flag;
          state         <= REPORT;
        end
        REPORT: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_share_ctrl.sv
// Directed bench for timer_share_ctrl with a presettable stub timer and a result scoreboard.
module tb_timer_share_ctrl;
  localparam int N       = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         t_en;
  logic [W-1:0] t_out;
  logic         preset_load = 1'b0;
  logic [W-1:0] preset_val  = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    int data;
    int to;
  } exp_t;
  exp_t sb[$];

  timer_share_ctrl_if #(.N(N), .W(W)) bus ();

  timer_share_ctrl #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .t_en  (t_en),
    .t_out (t_out)
  );

  always #5 clock = ~clock;

  // Stub shared timer: counts every edge while enabled, loadable for wrap tests.
  always @(posedge clock or posedge reset) begin
    if (reset)            t_out <= '0;
    else if (preset_load) t_out <= preset_val;
    else if (t_en)        t_out <= t_out + 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0 && bus.res_valid !== 1'b0) begin
      checkOutput("res_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("res_id",      32'(bus.res_id),      32'(e.id));
        checkOutput("res_data",    32'(bus.res_data),    32'(e.data));
        checkOutput("res_timeout", 32'(bus.res_timeout), 32'(e.to));
      end
    end
  end

  // how: 0 = done pulse, 1 = req drop for one cycle, 2 = req drop held, 3 = let it time out
  task automatic applyStimulus(input int id, input int k, input int how,
                               input int exp_data, input int exp_to);
    int n = 0;
    while (bus.grant === '0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("grant", 32'(bus.grant), 32'(1 << id));
    checkOutput("t_en_start", 32'(t_en), 32'd1);
    sb.push_back('{id: id, data: exp_data, to: exp_to});
    repeat (k) @(negedge clock);
    case (how)
      0: bus.done[id] = 1'b1;
      1, 2: bus.req[id] = 1'b0;
      default: ;
    endcase
    @(negedge clock);
    checkOutput("t_en_stop", 32'(t_en), 32'd0);
    if (how == 0) bus.done[id] = 1'b0;
    if (how == 1) bus.req[id] = 1'b1;
    @(negedge clock);
    checkOutput("grant_report", 32'(bus.grant), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.req  = '0;
    bus.done = '0;
    #12;
    checkOutput("rst_grant",       32'(bus.grant),       32'd0);
    checkOutput("rst_t_en",        32'(t_en),            32'd0);
    checkOutput("rst_res_valid",   32'(bus.res_valid),   32'd0);
    checkOutput("rst_res_id",      32'(bus.res_id),      32'd0);
    checkOutput("rst_res_data",    32'(bus.res_data),    32'd0);
    checkOutput("rst_res_timeout", 32'(bus.res_timeout), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] single requester with done");
    @(negedge clock);
    bus.req = 4'b0100;
    @(negedge clock);
    checkOutput("grant_latency", 32'(bus.grant), 32'b0100);
    applyStimulus(2, 3, 0, 4, 0);
    bus.req = '0;

    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] round robin 0,1,3,0");
    bus.req = 4'b1011;
    applyStimulus(0, 2, 1, 3, 0);
    applyStimulus(1, 2, 1, 3, 0);
    applyStimulus(3, 2, 1, 3, 0);
    applyStimulus(0, 2, 2, 3, 0);
    bus.req = '0;

    $display("[TB] timeout then re-grant");
    bus.req = 4'b0010;
    applyStimulus(1, TIMEOUT, 3, TIMEOUT + 1, 1);
    applyStimulus(1, 2, 2, 3, 0);
    bus.req = '0;

    $display("[TB] timer wrap");
    @(negedge clock);
    preset_val  = 16'hFFFE;
    preset_load = 1'b1;
    @(negedge clock);
    preset_load = 1'b0;
    bus.req = 4'b0001;
    applyStimulus(0, 3, 0, 4, 0);
    bus.req = '0;

    $display("[TB] done coincides with timeout");
    bus.req = 4'b0100;
    applyStimulus(2, TIMEOUT, 0, TIMEOUT + 1, 0);
    bus.req = '0;

    $display("[TB] reset during RUN");
    bus.req = 4'b0100;
    for (int n = 0; n < 50 && bus.grant === '0; n++) @(negedge clock);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_grant",     32'(bus.grant),     32'd0);
    checkOutput("mid_rst_t_en",      32'(t_en),          32'd0);
    checkOutput("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    bus.req = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    bus.req = 4'b1111;
    applyStimulus(0, 1, 2, 2, 0);
    bus.req = '0;

    repeat (4) @(negedge clock);
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
